// File: rtl/mdu_iterative.sv
// ---------------------------------------------------------------------------
// mdu_iterative
//   Iterative RV32M multiply/divide unit. It takes the RD1/RD2 operand values
//   from the register bank and produces a result plus a destination index for
//   WD3/A3/WE3. Only one operation is in flight at a time, and the core stalls
//   its PC while busy is high.
//
//   Multiplication is a shift-add, one step per cycle, over XLEN cycles.
//   Division is a restoring shift-subtract on magnitudes over XLEN cycles,
//   with the signs fixed up at the end. Divide-by-zero and signed overflow
//   skip the iteration and finish one cycle after accept.
//
//   Build option: define MDU_DIV_EN to include the divider datapath. When it
//   is not defined, funct3[2]=1 ops finish at once with result=0, we_out=0
//   and illegal=1.
//
// Ports
//   clk      in  rising-edge clock
//   rst      in  asynchronous reset, active-high
//   start    in  request, accepted only while busy=0
//   funct3   in  RV32M operation select
//   rs1_val  in  operand A (RD1)
//   rs2_val  in  operand B (RD2)
//   rd_in    in  destination register index
//   busy     out high from the accept edge through the done cycle
//   done     out one-cycle completion pulse
//   result   out computed value (WD3)
//   rd_out   out destination index (A3)
//   we_out   out write enable, done & (rd_out != 0) (WE3)
//   illegal  out pulses with done for ops compiled out
// ---------------------------------------------------------------------------
module mdu_iterative #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       rs1_val,
    input  logic [XLEN-1:0]       rs2_val,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  we_out,
    output logic                  illegal
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2*XLEN-1:0]     acc;
    logic [2*XLEN-1:0]     mcand;
    logic [XLEN-1:0]       mplier;

    logic                  a_signed;
    logic                  b_signed;
    logic [2*XLEN-1:0]     a_ext;
    logic [2*XLEN-1:0]     acc_init;
    logic [2*XLEN-1:0]     mul_acc_nx;
    logic [XLEN-1:0]       mul_res;
    logic [XLEN-1:0]       calc_res;

`ifdef MDU_DIV_EN
    logic [XLEN-1:0]       dq;
    logic [XLEN-1:0]       dr;
    logic [XLEN-1:0]       dv;
    logic                  neg_q;
    logic                  neg_r;
    logic                  div_signed;
    logic [XLEN-1:0]       a_abs;
    logic [XLEN-1:0]       b_abs;
    logic [XLEN:0]         div_shift;
    logic                  div_ge;
    logic [XLEN:0]         div_sub;
    logic [XLEN-1:0]       dq_nx;
    logic [XLEN-1:0]       dr_nx;
    logic [XLEN-1:0]       div_quot;
    logic [XLEN-1:0]       div_rem;
`endif

    // Operand preparation and one iteration step of each datapath.
    // rs2 is only walked over its low XLEN bits, so when a signed rs2 is
    // negative its sign-extension weight (-a * 2^XLEN) is preloaded into the
    // accumulator instead of spending extra cycles on the upper bits.
    always_comb begin
        a_signed   = (funct3[1:0] != 2'b11);
        b_signed   = ~funct3[1];
        a_ext      = a_signed ? {{XLEN{rs1_val[XLEN-1]}}, rs1_val}
                              : {{XLEN{1'b0}}, rs1_val};
        acc_init   = (b_signed && rs2_val[XLEN-1]) ? -(a_ext << XLEN) : '0;
        mul_acc_nx = acc + (mplier[0] ? mcand : '0);
        mul_res    = (op_q == 3'b000) ? mul_acc_nx[XLEN-1:0]
                                      : mul_acc_nx[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        div_signed = ~funct3[0];
        a_abs      = (div_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
        b_abs      = (div_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
        div_shift  = {dr, dq[XLEN-1]};
        div_ge     = (div_shift >= {1'b0, dv});
        div_sub    = div_shift - {1'b0, dv};
        dr_nx      = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
        dq_nx      = {dq[XLEN-2:0], div_ge};
        div_quot   = neg_q ? -dq_nx : dq_nx;
        div_rem    = neg_r ? -dr_nx : dr_nx;
        calc_res   = op_q[2] ? (op_q[1] ? div_rem : div_quot) : mul_res;
`else
        calc_res   = mul_res;
`endif
    end

    // Control FSM with registered outputs. IDLE latches the operands on
    // accept and either starts iterating or, for the short-circuit cases,
    // jumps straight to DONE. CALC runs XLEN steps. DONE holds busy for its
    // single done cycle and then returns to IDLE. Because start is only
    // looked at in IDLE, it is ignored in CALC and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            we_out  <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            counter <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`ifdef MDU_DIV_EN
            dq      <= '0;
            dr      <= '0;
            dv      <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        op_q    <= funct3;
                        rd_q    <= rd_in;
                        counter <= '0;
                        acc     <= acc_init;
                        mcand   <= a_ext;
                        mplier  <= rs2_val;
                        if (funct3[2]) begin
`ifdef MDU_DIV_EN
                            dq    <= a_abs;
                            dr    <= '0;
                            dv    <= b_abs;
                            neg_q <= div_signed & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                            neg_r <= div_signed & rs1_val[XLEN-1];
                            if (rs2_val == '0) begin
                                result <= funct3[1] ? rs1_val : '1;
                                rd_out <= rd_in;
                                done   <= 1'b1;
                                we_out <= (rd_in != '0);
                                state  <= DONE;
                            end else if (div_signed && rs1_val == INT_MIN && rs2_val == '1) begin
                                result <= funct3[1] ? '0 : INT_MIN;
                                rd_out <= rd_in;
                                done   <= 1'b1;
                                we_out <= (rd_in != '0);
                                state  <= DONE;
                            end else begin
                                state <= CALC;
                            end
`else
                            result  <= '0;
                            rd_out  <= rd_in;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            we_out  <= 1'b0;
                            state   <= DONE;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    counter <= counter + CW'(1);
                    acc     <= mul_acc_nx;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
`ifdef MDU_DIV_EN
                    dq      <= dq_nx;
                    dr      <= dr_nx;
`endif
                    if (counter == LAST) begin
                        result <= calc_res;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        we_out <= (rd_q != '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    we_out  <= 1'b0;
                    illegal <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// ---------------------------------------------------------------------------
// tb_mdu_iterative
//   Directed testbench for mdu_iterative with hand-computed expectations.
//   Divide expectations follow MDU_DIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mdu_iterative;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    mdu_iterative #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out),
        .illegal (illegal)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait for done. lat counts clock edges from the
    // accept edge (1 = done right after accept). The operand inputs are
    // scrambled after accept. With midPulse set, a competing start is driven
    // during CALC. Right after done, start is driven during the DONE cycle,
    // and busy must still be low after the following edge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit midPulse,
                                 output int lat, output logic [31:0] res, output logic [4:0] rdo,
                                 output logic we, output logic ill, output logic busyAfter);
        @(negedge clk);
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rs1_val = 32'hDEAD_BEEF;
        rs2_val = 32'h1234_5678;
        rd_in   = 5'd31;
        lat     = 1;
        while (!done && lat < 100) begin
            if (midPulse && lat == 10) begin
                funct3  = 3'b011;
                rs1_val = 32'hFFFF_FFFF;
                rs2_val = 32'hFFFF_FFFF;
                rd_in   = 5'd9;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        res   = result;
        rdo   = rd_out;
        we    = we_out;
        ill   = illegal;
        funct3  = 3'b000;
        rs1_val = 32'd3;
        rs2_val = 32'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        busyAfter = busy;
        start = 1'b0;
    endtask

    // Run one vector and compare every observable against the expectation
    task automatic runCase(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input bit midPulse,
                           input int expLat, input logic [31:0] expRes,
                           input logic expWe, input logic expIll);
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        we;
        logic        ill;
        logic        busyAfter;
        applyStimulus(f3, a, b, rd, midPulse, lat, res, rdo, we, ill, busyAfter);
        checkOutput({tag, "/lat"},     64'(lat),       64'(expLat));
        checkOutput({tag, "/result"},  64'(res),       64'(expRes));
        checkOutput({tag, "/rd_out"},  64'(rdo),       64'(rd));
        checkOutput({tag, "/we_out"},  64'(we),        64'(expWe));
        checkOutput({tag, "/illegal"}, 64'(ill),       64'(expIll));
        checkOutput({tag, "/busy0"},   64'(busyAfter), 64'(0));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'b000;
        rs1_val = '0;
        rs2_val = '0;
        rd_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/busy",    64'(busy),    64'(0));
        checkOutput("reset/done",    64'(done),    64'(0));
        checkOutput("reset/we_out",  64'(we_out),  64'(0));
        checkOutput("reset/illegal", 64'(illegal), 64'(0));
        checkOutput("reset/result",  64'(result),  64'(0));
        checkOutput("reset/rd_out",  64'(rd_out),  64'(0));
        @(negedge clk);
        rst = 1'b0;

        runCase("mul_7x-3",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5, 1'b0, 33, 32'hFFFF_FFEB, 1'b1, 1'b0);
        runCase("mulhu_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, 33, 32'hFFFF_FFFE, 1'b1, 1'b0);
        runCase("mulh_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 33, 32'h0000_0000, 1'b1, 1'b0);
        runCase("mulhsu_-1x2",3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8, 1'b0, 33, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runCase("mul_rd0",    3'b000, 32'd3,         32'd4,         5'd0, 1'b0, 33, 32'd12,        1'b0, 1'b0);
        runCase("mul_ignore", 3'b000, 32'd5,         32'd6,         5'd7, 1'b1, 33, 32'd30,        1'b1, 1'b0);
`ifdef MDU_DIV_EN
        runCase("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd3, 1'b0, 33, 32'hFFFF_FFFD, 1'b1, 1'b0);
        runCase("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd3, 1'b0, 33, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runCase("divu_100/7", 3'b101, 32'd100,       32'd7,         5'd4, 1'b0, 33, 32'd14,        1'b1, 1'b0);
        runCase("remu_100/7", 3'b111, 32'd100,       32'd7,         5'd4, 1'b0, 33, 32'd2,         1'b1, 1'b0);
        runCase("divu_0/0",   3'b101, 32'd0,         32'd0,         5'd2, 1'b0, 1,  32'hFFFF_FFFF, 1'b1, 1'b0);
        runCase("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b0, 1,  32'h0000_0000, 1'b1, 1'b0);
        runCase("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b0, 1,  32'h8000_0000, 1'b1, 1'b0);
        runCase("div_8/2",    3'b100, 32'd8,         32'd2,         5'd4, 1'b0, 33, 32'd4,         1'b1, 1'b0);
`else
        runCase("div_8/2",    3'b100, 32'd8,         32'd2,         5'd4, 1'b0, 1,  32'd0,         1'b0, 1'b1);
        runCase("remu_100/7", 3'b111, 32'd100,       32'd7,         5'd4, 1'b0, 1,  32'd0,         1'b0, 1'b1);
        runCase("divu_0/0",   3'b101, 32'd0,         32'd0,         5'd2, 1'b0, 1,  32'd0,         1'b0, 1'b1);
`endif

        // Reset in the middle of CALC clears the unit at once, without
        // waiting for a clock edge
        @(negedge clk);
        funct3  = 3'b000;
        rs1_val = 32'd9;
        rs2_val = 32'd9;
        rd_in   = 5'd2;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("midrst/busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("midrst/busy",   64'(busy),   64'(0));
        checkOutput("midrst/done",   64'(done),   64'(0));
        checkOutput("midrst/rd_out", 64'(rd_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        runCase("mul_after_rst", 3'b000, 32'd9, 32'd9, 5'd2, 1'b0, 33, 32'd81, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
